// File: rtl/drp_pkg.sv
// Shared types and constants for the DRP port arbiter.
package drp_pkg;

  localparam int unsigned DRP_DW      = 16;
  localparam logic [15:0] FULL_MASK   = 16'hFFFF;
  localparam int unsigned TIMEOUT_DEF = 1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RESP
  } drp_state_e;

  // Bits with mask=1 come from the new data, the rest keep the read value.
  function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] rd,
                                                  input logic [DRP_DW-1:0] wd,
                                                  input logic [DRP_DW-1:0] mask);
    return (rd & ~mask) | (wd & mask);
  endfunction

endpackage

// File: rtl/drp_rr_arbiter.sv
// Round-robin grant: combinational one-hot pick starting at the pointer,
// plus the pointer register advanced past the served requester.
module drp_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  input  logic [IW-1:0]      upd_idx_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               any_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = (32'(upd_idx_i) == NUM_REQ - 1) ? '0 : upd_idx_i + 1'b1;
  end

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/drp_arbiter.sv
// Shares one transceiver DRP port between NUM_REQ requesters with round-robin
// arbitration, read / write / masked read-modify-write and a ready timeout.
module drp_arbiter import drp_pkg::*; #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DRP_AW      = 9,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DRP_AW-1:0] req_addr,
  input  logic [NUM_REQ*DRP_DW-1:0] req_wdata,
  input  logic [NUM_REQ*DRP_DW-1:0] req_mask,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DRP_DW-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      drp_en,
  output logic                      drp_we,
  output logic [DRP_AW-1:0]         drp_addr,
  output logic [DRP_DW-1:0]         drp_di,
  input  logic [DRP_DW-1:0]         drp_do,
  input  logic                      drp_rdy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  drp_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                we_q, we_d;
  logic [DRP_DW-1:0]   wdata_q, wdata_d, mask_q, mask_d;
  logic [DRP_AW-1:0]   addr_q, addr_d;
  logic [DRP_DW-1:0]   di_q, di_d, rdata_q, rdata_d;
  logic                err_q, err_d, en_q, en_d, dwe_q, dwe_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IW-1:0]       rr_idx;
  logic                rr_any, rr_upd;
  logic                sel_we;
  logic [DRP_AW-1:0]   sel_addr;
  logic [DRP_DW-1:0]   sel_wdata, sel_mask;

  drp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .upd_i     (rr_upd),
    .upd_idx_i (idx_q),
    .gnt_o     (rr_gnt),
    .gnt_idx_o (rr_idx),
    .any_o     (rr_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rr_gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*DRP_AW +: DRP_AW];
        sel_wdata = req_wdata[i*DRP_DW +: DRP_DW];
        sel_mask  = req_mask[i*DRP_DW +: DRP_DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      di_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      dwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      en_q    <= en_d;
      dwe_q   <= dwe_d;
    end
  end

  // Strobes are registered, so they are raised on the transition into ISSUE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    en_d    = 1'b0;
    dwe_d   = 1'b0;
    rr_upd  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rr_any) begin
          gnt_d   = rr_gnt;
          idx_d   = rr_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          mask_d  = sel_mask;
          rdata_d = '0;
          err_d   = 1'b0;
          en_d    = 1'b1;
          if (sel_we && sel_mask == FULL_MASK) begin
            state_d = S_WR_ISSUE;
            dwe_d   = 1'b1;
            di_d    = sel_wdata;
          end else begin
            state_d = S_RD_ISSUE;
            di_d    = '0;
          end
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_WR_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_RD_WAIT: begin
        if (drp_rdy) begin
          rdata_d = drp_do;
          if (we_q) begin
            di_d    = rmw_merge(drp_do, wdata_q, mask_q);
            en_d    = 1'b1;
            dwe_d   = 1'b1;
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (drp_rdy) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_upd  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ack   = (state_q == S_RESP) ? gnt_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign drp_en    = en_q;
  assign drp_we    = dwe_q;
  assign drp_addr  = addr_q;
  assign drp_di    = di_q;

endmodule
